// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoding definitions: operation enum, opcodes, funct fields,
// packing formats and the immediate range helper.
package instruction_encoder_pkg;

    typedef enum logic [4:0] {
        ENC_ADD, ENC_SUB, ENC_SLL, ENC_SRL, ENC_SRA,
        ENC_XOR, ENC_OR, ENC_AND, ENC_SLT, ENC_SLTU,
        ENC_ADDI, ENC_XORI, ENC_ORI, ENC_ANDI, ENC_SLTI, ENC_SLTIU,
        ENC_SLLI, ENC_SRLI, ENC_SRAI,
        ENC_LW, ENC_SW,
        ENC_BEQ, ENC_BNE, ENC_BLT, ENC_BGE, ENC_BLTU, ENC_BGEU,
        ENC_LUI
    } enc_op_type;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_SHIFT, FMT_LOAD, FMT_STORE, FMT_BRANCH, FMT_LUI
    } enc_fmt_type;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // True when a 32-bit value is representable as a 12-bit signed immediate.
    function automatic logic fits_simm12(input logic signed [31:0] imm);
        return (imm[31:11] == '0) || (imm[31:11] == '1);
    endfunction

endpackage

// File: rtl/instruction_encoder_packer.sv
// Combinational packer: symbolic operation plus fields to a 32-bit RV32I word
// and a legality flag (immediate range and operation encoding).
module instruction_packer
    import instruction_encoder_pkg::*;
(
    input  enc_op_type         op,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic signed [31:0] imm,
    output logic [31:0]        word,
    output logic               legal
);

    enc_fmt_type fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;

    // Classify the operation into a format with its funct3/funct7.
    always_comb begin
        fmt = FMT_NONE;
        f3  = 3'b000;
        f7  = F7_BASE;
        case (op)
            ENC_ADD:   begin fmt = FMT_R; f3 = F3_ADD_SUB; end
            ENC_SUB:   begin fmt = FMT_R; f3 = F3_ADD_SUB; f7 = F7_ALT; end
            ENC_SLL:   begin fmt = FMT_R; f3 = F3_SLL; end
            ENC_SRL:   begin fmt = FMT_R; f3 = F3_SRL_SRA; end
            ENC_SRA:   begin fmt = FMT_R; f3 = F3_SRL_SRA; f7 = F7_ALT; end
            ENC_XOR:   begin fmt = FMT_R; f3 = F3_XOR; end
            ENC_OR:    begin fmt = FMT_R; f3 = F3_OR; end
            ENC_AND:   begin fmt = FMT_R; f3 = F3_AND; end
            ENC_SLT:   begin fmt = FMT_R; f3 = F3_SLT; end
            ENC_SLTU:  begin fmt = FMT_R; f3 = F3_SLTU; end
            ENC_ADDI:  begin fmt = FMT_I; f3 = F3_ADD_SUB; end
            ENC_XORI:  begin fmt = FMT_I; f3 = F3_XOR; end
            ENC_ORI:   begin fmt = FMT_I; f3 = F3_OR; end
            ENC_ANDI:  begin fmt = FMT_I; f3 = F3_AND; end
            ENC_SLTI:  begin fmt = FMT_I; f3 = F3_SLT; end
            ENC_SLTIU: begin fmt = FMT_I; f3 = F3_SLTU; end
            ENC_SLLI:  begin fmt = FMT_SHIFT; f3 = F3_SLL; end
            ENC_SRLI:  begin fmt = FMT_SHIFT; f3 = F3_SRL_SRA; end
            ENC_SRAI:  begin fmt = FMT_SHIFT; f3 = F3_SRL_SRA; f7 = F7_ALT; end
            ENC_LW:    begin fmt = FMT_LOAD; f3 = F3_WORD; end
            ENC_SW:    begin fmt = FMT_STORE; f3 = F3_WORD; end
            ENC_BEQ:   begin fmt = FMT_BRANCH; f3 = F3_BEQ; end
            ENC_BNE:   begin fmt = FMT_BRANCH; f3 = F3_BNE; end
            ENC_BLT:   begin fmt = FMT_BRANCH; f3 = F3_BLT; end
            ENC_BGE:   begin fmt = FMT_BRANCH; f3 = F3_BGE; end
            ENC_BLTU:  begin fmt = FMT_BRANCH; f3 = F3_BLTU; end
            ENC_BGEU:  begin fmt = FMT_BRANCH; f3 = F3_BGEU; end
            ENC_LUI:   begin fmt = FMT_LUI; end
            default:   begin fmt = FMT_NONE; end
        endcase
    end

    // Place fields per format; unused register fields stay zero.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                word  = {f7, rs2, rs1, f3, rd, OPC_OP};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
                legal = fits_simm12(imm);
            end
            FMT_SHIFT: begin
                word  = {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
                legal = (imm[31:5] == '0);
            end
            FMT_LOAD: begin
                word  = {imm[11:0], rs1, f3, rd, OPC_LOAD};
                legal = fits_simm12(imm);
            end
            FMT_STORE: begin
                word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
                legal = fits_simm12(imm);
            end
            FMT_BRANCH: begin
                word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
                legal = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
            end
            FMT_LUI: begin
                word  = {imm[31:12], rd, OPC_LUI};
                legal = (imm[11:0] == '0);
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Instruction memory writer: accepts symbolic requests, encodes them and
// writes them to sequential word addresses with memory backpressure.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  enc_op_type            req_op,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_rs1,
    input  logic [4:0]            req_rs2,
    input  logic signed [31:0]    req_imm,
    input  logic                  load_addr,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  imem_we,
    input  logic                  imem_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  err,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH:0]   words_written
);

    function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [ADDR_WIDTH:0] sat_inc_words(input logic [ADDR_WIDTH:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [31:0]           word_p0;
    logic                  legal_p0;
    logic                  accept_p0;
    logic                  write_hs;
    logic                  vld_p1;
    logic [31:0]           wdata_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic                  err_p1;
    logic [7:0]            err_cnt_p1;
    logic [ADDR_WIDTH:0]   words_p1;

    instruction_packer u_packer (
        .op    (req_op),
        .rd    (req_rd),
        .rs1   (req_rs1),
        .rs2   (req_rs2),
        .imm   (req_imm),
        .word  (word_p0),
        .legal (legal_p0)
    );

    assign req_ready = !rst && (!vld_p1 || imem_ready);
    assign accept_p0 = req_valid && req_ready;
    assign write_hs  = vld_p1 && imem_ready;

    // ---- stage p0 -> p1: encoded word into the output register ----

    // Output register: loaded by a legal accept, emptied by a write handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            wdata_p1 <= '0;
        end else if (accept_p0 && legal_p0) begin
            vld_p1   <= 1'b1;
            wdata_p1 <= word_p0;
        end else if (write_hs) begin
            vld_p1   <= 1'b0;
        end
    end

    // Write pointer and completed-write count; a load overrides the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p1  <= '0;
            words_p1 <= '0;
        end else if (load_addr) begin
            addr_p1  <= base_addr;
            words_p1 <= '0;
        end else if (write_hs) begin
            addr_p1  <= addr_p1 + 1'b1;
            words_p1 <= sat_inc_words(words_p1);
        end
    end

    // Sticky error flag and saturating count of rejected requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_p1     <= 1'b0;
            err_cnt_p1 <= '0;
        end else if (accept_p0 && !legal_p0) begin
            err_p1     <= 1'b1;
            err_cnt_p1 <= sat_inc_err(err_cnt_p1);
        end
    end

    assign imem_we       = vld_p1;
    assign imem_wdata    = wdata_p1;
    assign imem_addr     = addr_p1;
    assign err           = err_p1;
    assign err_count     = err_cnt_p1;
    assign words_written = words_p1;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: vector table plus multi-cycle
// sequences for back-to-back writes, backpressure, wrap, load and reset.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    enc_op_type         req_op;
    logic [4:0]         req_rd, req_rs1, req_rs2;
    logic signed [31:0] req_imm;
    logic               load_addr;
    logic [7:0]         base_addr;
    logic               imem_we;
    logic               imem_ready;
    logic [7:0]         imem_addr;
    logic [31:0]        imem_wdata;
    logic               err;
    logic [7:0]         err_count;
    logic [8:0]         words_written;

    int checks = 0;
    int errors = 0;

    instruction_encoder #(.ADDR_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_rd        (req_rd),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_imm       (req_imm),
        .load_addr     (load_addr),
        .base_addr     (base_addr),
        .imem_we       (imem_we),
        .imem_ready    (imem_ready),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .err           (err),
        .err_count     (err_count),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        enc_op_type  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic        legal;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input enc_op_type op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        req_op  = op;
        req_rd  = rd;
        req_rs1 = rs1;
        req_rs2 = rs2;
        req_imm = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_addr;
    logic [8:0] exp_ww;
    logic [7:0] exp_err;

    initial begin
        vecs[0]  = '{ENC_ADDI,  5'd1,  5'd0,  5'd7,  32'd5,          32'h00500093, 1'b1};
        vecs[1]  = '{ENC_SUB,   5'd3,  5'd1,  5'd2,  32'd0,          32'h402081B3, 1'b1};
        vecs[2]  = '{ENC_SW,    5'd5,  5'd1,  5'd2,  32'd8,          32'h0020A423, 1'b1};
        vecs[3]  = '{ENC_BEQ,   5'd9,  5'd1,  5'd2,  32'hFFFFFFFC,   32'hFE208EE3, 1'b1};
        vecs[4]  = '{ENC_LUI,   5'd5,  5'd0,  5'd0,  32'h12345000,   32'h123452B7, 1'b1};
        vecs[5]  = '{ENC_SRAI,  5'd1,  5'd1,  5'd0,  32'd3,          32'h4030D093, 1'b1};
        vecs[6]  = '{ENC_ADDI,  5'd1,  5'd0,  5'd0,  32'd2048,       32'h0,        1'b0};
        vecs[7]  = '{ENC_BEQ,   5'd0,  5'd1,  5'd2,  32'd3,          32'h0,        1'b0};
        vecs[8]  = '{ENC_LUI,   5'd5,  5'd0,  5'd0,  32'h00000001,   32'h0,        1'b0};
        vecs[9]  = '{ENC_ADDI,  5'd1,  5'd0,  5'd0,  32'hFFFFF800,   32'h80000093, 1'b1};
        vecs[10] = '{ENC_LW,    5'd5,  5'd6,  5'd0,  32'hFFFFFFFF,   32'hFFF32283, 1'b1};
        vecs[11] = '{ENC_SLTU,  5'd10, 5'd11, 5'd12, 32'd0,          32'h00C5B533, 1'b1};
        vecs[12] = '{enc_op_type'(5'd31), 5'd1, 5'd1, 5'd1, 32'd0,   32'h0,        1'b0};
        vecs[13] = '{ENC_SLLI,  5'd1,  5'd1,  5'd0,  32'd32,         32'h0,        1'b0};

        rst = 1'b1; req_valid = 1'b0; imem_ready = 1'b1; load_addr = 1'b0; base_addr = '0;
        set_req(ENC_ADD, 5'd0, 5'd0, 5'd0, 32'd0);

        // Reset state
        #12;
        check("rst_we",    32'(imem_we), 32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_errc",  32'(err_count), 32'd0);
        check("rst_ww",    32'(words_written), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Load base 0x10
        tick();
        load_addr = 1'b1; base_addr = 8'h10;
        tick();
        load_addr = 1'b0;
        check("load_addr", 32'(imem_addr), 32'h10);
        check("load_ww",   32'(words_written), 32'd0);
        exp_addr = 8'h10; exp_ww = '0; exp_err = '0;

        // Table-driven single requests
        for (int i = 0; i < NV; i++) begin
            set_req(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            req_valid = 1'b1;
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
            tick();
            req_valid = 1'b0;
            check($sformatf("v%0d_we", i), 32'(imem_we), 32'(vecs[i].legal));
            if (vecs[i].legal) begin
                check($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].word);
            end else begin
                exp_err = exp_err + 8'd1;
            end
            check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(exp_addr));
            check($sformatf("v%0d_err", i), 32'(err), 32'(exp_err != 0));
            check($sformatf("v%0d_errc", i), 32'(err_count), 32'(exp_err));
            tick();
            if (vecs[i].legal) begin
                exp_addr = exp_addr + 8'd1;
                exp_ww   = exp_ww + 9'd1;
            end
            check($sformatf("v%0d_we_done", i), 32'(imem_we), 32'd0);
            check($sformatf("v%0d_addr_next", i), 32'(imem_addr), 32'(exp_addr));
            check($sformatf("v%0d_ww", i), 32'(words_written), 32'(exp_ww));
        end

        // Back-to-back SUB then SW, no bubble
        set_req(ENC_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        req_valid = 1'b1;
        tick();
        set_req(ENC_SW, 5'd0, 5'd1, 5'd2, 32'd8);
        check("b2b_we0",    32'(imem_we), 32'd1);
        check("b2b_wdata0", imem_wdata, 32'h402081B3);
        check("b2b_addr0",  32'(imem_addr), 32'(exp_addr));
        tick();
        req_valid = 1'b0;
        check("b2b_we1",    32'(imem_we), 32'd1);
        check("b2b_wdata1", imem_wdata, 32'h0020A423);
        check("b2b_addr1",  32'(imem_addr), 32'(exp_addr + 8'd1));
        tick();
        exp_addr = exp_addr + 8'd2; exp_ww = exp_ww + 9'd2;
        check("b2b_we_done", 32'(imem_we), 32'd0);
        check("b2b_addr2",   32'(imem_addr), 32'(exp_addr));
        check("b2b_ww",      32'(words_written), 32'(exp_ww));

        // Memory backpressure for 3 cycles with next request pending
        imem_ready = 1'b0;
        set_req(ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        req_valid = 1'b1;
        tick();
        set_req(ENC_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
            check($sformatf("bp%0d_we", c), 32'(imem_we), 32'd1);
            check($sformatf("bp%0d_wdata", c), imem_wdata, 32'h00500093);
            check($sformatf("bp%0d_addr", c), 32'(imem_addr), 32'(exp_addr));
            check($sformatf("bp%0d_ww", c), 32'(words_written), 32'(exp_ww));
            if (c < 2) tick();
        end
        imem_ready = 1'b1;
        #1;
        check("bp_ready_rel", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("bp_wdata_b", imem_wdata, 32'h402081B3);
        check("bp_addr_b",  32'(imem_addr), 32'(exp_addr + 8'd1));
        check("bp_ww_a",    32'(words_written), 32'(exp_ww + 9'd1));
        tick();
        exp_addr = exp_addr + 8'd2; exp_ww = exp_ww + 9'd2;
        check("bp_we_done", 32'(imem_we), 32'd0);
        check("bp_addr_end", 32'(imem_addr), 32'(exp_addr));
        check("bp_ww_end",   32'(words_written), 32'(exp_ww));

        // Wrap at 0xFF, then load colliding with a write handshake
        load_addr = 1'b1; base_addr = 8'hFF;
        tick();
        load_addr = 1'b0;
        check("wrap_load", 32'(imem_addr), 32'hFF);
        set_req(ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        req_valid = 1'b1;
        tick();
        set_req(ENC_SRAI, 5'd1, 5'd1, 5'd0, 32'd3);
        check("wrap_addr0", 32'(imem_addr), 32'hFF);
        check("wrap_wd0",   imem_wdata, 32'h00500093);
        tick();
        req_valid = 1'b0;
        check("wrap_addr1", 32'(imem_addr), 32'h00);
        check("wrap_wd1",   imem_wdata, 32'h4030D093);
        check("wrap_ww1",   32'(words_written), 32'd1);
        load_addr = 1'b1; base_addr = 8'h40;
        tick();
        load_addr = 1'b0;
        check("coll_we",   32'(imem_we), 32'd0);
        check("coll_addr", 32'(imem_addr), 32'h40);
        check("coll_ww",   32'(words_written), 32'd0);

        // Asynchronous reset while a write is pending
        imem_ready = 1'b0;
        set_req(ENC_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("pre_rst_we", 32'(imem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_we",    32'(imem_we), 32'd0);
        check("arst_addr",  32'(imem_addr), 32'd0);
        check("arst_wdata", imem_wdata, 32'd0);
        check("arst_err",   32'(err), 32'd0);
        check("arst_errc",  32'(err_count), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd0);
        #1;
        rst = 1'b0;
        imem_ready = 1'b1;
        tick();
        tick();
        check("post_rst_we",    32'(imem_we), 32'd0);
        check("post_rst_addr",  32'(imem_addr), 32'd0);
        check("post_rst_ww",    32'(words_written), 32'd0);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
